// File: rtl/load_store_unit_pkg.sv
// Shared types and bus encodings for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    RMW_RD,
    RMW_WR,
    STORE
  } lsu_state_e;

  localparam logic [1:0] TRANS_IDLE = 2'b00;
  localparam logic [1:0] TRANS_NSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ  = 2'b11;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

endpackage

// File: rtl/load_store_unit_if.sv
// Request, fetch, memory-bus and result signals of the load/store unit.
interface load_store_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_write_i;
  logic              req_byte_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [31:0]       req_wdata_i;
  logic [3:0]        req_dest_i;

  logic              fetch_req_i;
  logic [ADDR_W-1:0] fetch_addr_i;
  logic              fetch_valid_o;
  logic [31:0]       fetch_instr_o;

  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;
  logic              mem_abort_i;
  logic              mem_data_valid_i;
  logic              mem_write_o;
  logic              mem_size_o;
  logic [1:0]        mem_trans_o;

  logic              ld_valid_o;
  logic [3:0]        ld_dest_o;
  logic [31:0]       ld_data_o;
  logic              abort_o;

  // LSU side
  modport slave (
    input  req_valid_i, req_write_i, req_byte_i, req_addr_i, req_wdata_i, req_dest_i,
    input  fetch_req_i, fetch_addr_i,
    input  mem_rdata_i, mem_abort_i, mem_data_valid_i,
    output req_ready_o, fetch_valid_o, fetch_instr_o,
    output mem_addr_o, mem_wdata_o, mem_write_o, mem_size_o, mem_trans_o,
    output ld_valid_o, ld_dest_o, ld_data_o, abort_o
  );

  // Execute stage, fetch stage and memory side
  modport master (
    output req_valid_i, req_write_i, req_byte_i, req_addr_i, req_wdata_i, req_dest_i,
    output fetch_req_i, fetch_addr_i,
    output mem_rdata_i, mem_abort_i, mem_data_valid_i,
    input  req_ready_o, fetch_valid_o, fetch_instr_o,
    input  mem_addr_o, mem_wdata_o, mem_write_o, mem_size_o, mem_trans_o,
    input  ld_valid_o, ld_dest_o, ld_data_o, abort_o
  );
endinterface

// File: rtl/load_store_unit_byte_lane.sv
// Byte-lane helper: zero-extended byte extraction for loads and byte merge for stores.
module byte_lane_unit (
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] load_byte_o,
  output logic [31:0] merged_o
);

  always_comb begin
    load_byte_o      = '0;
    load_byte_o[7:0] = word_i[{lane_i, 3'b000} +: 8];
    merged_o         = word_i;
    merged_o[{lane_i, 3'b000} +: 8] = byte_i;
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: arbitrates fetch vs. data requests on the single memory port,
// sequencing word/byte loads, word stores and read-modify-write byte stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_W         = 32
) (
  input logic               clk,
  input logic               reset,
  load_store_unit_if.slave  bus
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e state, state_d;

  logic [CNT_W-1:0]  cnt;
  logic              r_byte;
  logic [1:0]        r_lane;
  logic [7:0]        r_wbyte;
  logic [3:0]        r_dest;
  logic [ADDR_W-1:0] last_fetch_addr;
  logic              last_fetch_valid;

  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              mem_write_q;
  logic              mem_size_q;
  logic [1:0]        mem_trans_q;
  logic              ld_valid_q;
  logic [3:0]        ld_dest_q;
  logic [31:0]       ld_data_q;
  logic              fetch_valid_q;
  logic [31:0]       fetch_instr_q;
  logic              abort_q;

  logic              issue, issue_write;
  logic [1:0]        issue_trans;
  logic [ADDR_W-1:0] issue_addr;
  logic [31:0]       issue_wdata;
  logic              accept, fetch_start, cnt_inc;
  logic              ld_fire, fetch_fire, abort_fire;
  logic              lfv_set, lfv_clr;
  logic              fetch_is_seq;

  logic [31:0]       lane_load, lane_merged;

  byte_lane_unit u_lane (
    .word_i      (bus.mem_rdata_i),
    .lane_i      (r_lane),
    .byte_i      (r_wbyte),
    .load_byte_o (lane_load),
    .merged_o    (lane_merged)
  );

  assign fetch_is_seq = last_fetch_valid && (bus.fetch_addr_i == last_fetch_addr + ADDR_W'(4));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d     = state;
    issue       = 1'b0;
    issue_write = 1'b0;
    issue_trans = TRANS_NSEQ;
    issue_addr  = {bus.req_addr_i[ADDR_W-1:2], 2'b00};
    issue_wdata = bus.req_wdata_i;
    accept      = 1'b0;
    fetch_start = 1'b0;
    cnt_inc     = 1'b0;
    ld_fire     = 1'b0;
    fetch_fire  = 1'b0;
    abort_fire  = 1'b0;
    lfv_set     = 1'b0;
    lfv_clr     = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.req_valid_i) begin
          accept  = 1'b1;
          issue   = 1'b1;
          lfv_clr = 1'b1;
          if (!bus.req_write_i) begin
            state_d = LOAD;
          end else if (bus.req_byte_i) begin
            state_d = RMW_RD;
          end else begin
            state_d     = STORE;
            issue_write = 1'b1;
          end
        end else if (bus.fetch_req_i) begin
          fetch_start = 1'b1;
          issue       = 1'b1;
          issue_addr  = {bus.fetch_addr_i[ADDR_W-1:2], 2'b00};
          issue_trans = fetch_is_seq ? TRANS_SEQ : TRANS_NSEQ;
          state_d     = FETCH;
        end
      end

      default: begin
        if (bus.mem_data_valid_i) begin
          if (bus.mem_abort_i) begin
            abort_fire = 1'b1;
            lfv_clr    = (state == FETCH);
            state_d    = IDLE;
          end else begin
            unique case (state)
              FETCH: begin
                fetch_fire = 1'b1;
                lfv_set    = 1'b1;
                state_d    = IDLE;
              end
              LOAD: begin
                ld_fire = 1'b1;
                state_d = IDLE;
              end
              RMW_RD: begin
                // Read half done: write back the same word with one lane replaced
                issue       = 1'b1;
                issue_write = 1'b1;
                issue_addr  = mem_addr_q;
                issue_wdata = lane_merged;
                state_d     = RMW_WR;
              end
              default: state_d = IDLE;
            endcase
          end
        end else if (cnt == CNT_LAST) begin
          abort_fire = 1'b1;
          lfv_clr    = (state == FETCH);
          state_d    = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt              <= '0;
      r_byte           <= 1'b0;
      r_lane           <= '0;
      r_wbyte          <= '0;
      r_dest           <= '0;
      last_fetch_addr  <= '0;
      last_fetch_valid <= 1'b0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      mem_write_q      <= 1'b0;
      mem_size_q       <= SIZE_BYTE;
      mem_trans_q      <= TRANS_IDLE;
      ld_valid_q       <= 1'b0;
      ld_dest_q        <= '0;
      ld_data_q        <= '0;
      fetch_valid_q    <= 1'b0;
      fetch_instr_q    <= '0;
      abort_q          <= 1'b0;
    end else begin
      ld_valid_q    <= ld_fire;
      fetch_valid_q <= fetch_fire;
      abort_q       <= abort_fire;
      mem_trans_q   <= issue ? issue_trans : TRANS_IDLE;
      mem_write_q   <= issue && issue_write;

      if (issue) begin
        mem_addr_q <= issue_addr;
        mem_size_q <= SIZE_WORD;
        cnt        <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (issue && issue_write) mem_wdata_q <= issue_wdata;

      if (accept) begin
        r_byte  <= bus.req_byte_i;
        r_lane  <= bus.req_addr_i[1:0];
        r_wbyte <= bus.req_wdata_i[7:0];
        r_dest  <= bus.req_dest_i;
      end

      if (ld_fire) begin
        ld_data_q <= r_byte ? lane_load : bus.mem_rdata_i;
        ld_dest_q <= r_dest;
      end
      if (fetch_fire) fetch_instr_q <= bus.mem_rdata_i;

      if (fetch_start) last_fetch_addr <= bus.fetch_addr_i;
      if (lfv_clr)      last_fetch_valid <= 1'b0;
      else if (lfv_set) last_fetch_valid <= 1'b1;
    end
  end

  assign bus.req_ready_o   = (state == IDLE) && !reset;
  assign bus.mem_addr_o    = mem_addr_q;
  assign bus.mem_wdata_o   = mem_wdata_q;
  assign bus.mem_write_o   = mem_write_q;
  assign bus.mem_size_o    = mem_size_q;
  assign bus.mem_trans_o   = mem_trans_q;
  assign bus.ld_valid_o    = ld_valid_q;
  assign bus.ld_dest_o     = ld_dest_q;
  assign bus.ld_data_o     = ld_data_q;
  assign bus.fetch_valid_o = fetch_valid_q;
  assign bus.fetch_instr_o = fetch_instr_q;
  assign bus.abort_o       = abort_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a word-array memory model.
module tb_load_store_unit;

  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(32)) bus ();

  load_store_unit #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory seen through the DUT bus, and the bench's own expected memory
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  int cyc = 0, ld_cnt = 0, f_cnt = 0, ab_cnt = 0;
  int issue_cnt = 0, wr_issue = 0, wr_bad = 0, bus_bad = 0;
  int last_ld_cyc = 0, last_ab_cyc = 0, issue_cyc = 0;
  logic [31:0] last_ld_data = '0, last_f = '0;
  logic [3:0]  last_ld_dest = '0;
  logic [1:0]  last_trans = '0;
  int ev_q[$];

  int resp_lat = 1;
  bit stall_mode = 1'b0, abort_next = 1'b0;
  bit pend = 1'b0, p_write = 1'b0;
  int wleft = 0;
  logic [31:0] p_addr = '0, p_wdata = '0;

  bit pf_ok = 1'b0;
  logic [31:0] pf_addr = '0;

  // Memory responder and output monitor, evaluated just after each rising edge
  initial begin
    bus.mem_data_valid_i = 1'b0;
    bus.mem_abort_i      = 1'b0;
    bus.mem_rdata_i      = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bus.mem_data_valid_i = 1'b0;
      bus.mem_abort_i      = 1'b0;
      if (bus.ld_valid_o) begin
        ld_cnt++; last_ld_data = bus.ld_data_o; last_ld_dest = bus.ld_dest_o;
        last_ld_cyc = cyc; ev_q.push_back(1);
      end
      if (bus.fetch_valid_o) begin
        f_cnt++; last_f = bus.fetch_instr_o; ev_q.push_back(2);
      end
      if (bus.abort_o) begin
        ab_cnt++; last_ab_cyc = cyc;
      end
      if (bus.mem_write_o && bus.mem_trans_o == 2'b00) wr_bad++;
      if (pend) begin
        if (wleft == 0) begin
          pend = 1'b0;
          bus.mem_data_valid_i = 1'b1;
          bus.mem_abort_i      = abort_next;
          bus.mem_rdata_i      = mem[p_addr[9:2]];
          if (abort_next) abort_next = 1'b0;
          else if (p_write) mem[p_addr[9:2]] = p_wdata;
        end else begin
          wleft--;
        end
      end
      if (bus.mem_trans_o != 2'b00) begin
        issue_cnt++;
        issue_cyc  = cyc;
        last_trans = bus.mem_trans_o;
        if (bus.mem_write_o) wr_issue++;
        if (bus.mem_size_o !== 1'b1 || bus.mem_addr_o[1:0] != 2'b00) bus_bad++;
        p_addr  = bus.mem_addr_o;
        p_write = bus.mem_write_o;
        p_wdata = bus.mem_wdata_o;
        pend    = !stall_mode;
        wleft   = resp_lat - 1;
      end
    end
  end

  task automatic do_data(input bit wr, input bit by, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] dest,
                         input bit abrt, input bit chk_lat);
    int ld0, ab0, k, acc_cyc, sh;
    logic [31:0] w, exp;
    ld0 = ld_cnt;
    ab0 = ab_cnt;
    abort_next = abrt && !stall_mode;
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_write_i = wr;
    bus.req_byte_i  = by;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wdata;
    bus.req_dest_i  = dest;
    k = 0;
    while (!bus.req_ready_o && k < 64) begin @(negedge clk); k++; end
    acc_cyc = cyc + 1;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    check("busy_ready", 32'(bus.req_ready_o), 0);
    k = 0;
    while (!bus.req_ready_o && k < 64) begin @(negedge clk); k++; end
    check("data_done", (k < 64) ? 1 : 0, 1);
    pf_ok = 1'b0;
    w  = ref_mem[addr[9:2]];
    sh = 8 * int'(addr[1:0]);
    check("abort_cnt", ab_cnt - ab0, abrt ? 1 : 0);
    if (!wr) begin
      check("ld_cnt", ld_cnt - ld0, abrt ? 0 : 1);
      if (!abrt) begin
        exp = by ? ((w >> sh) & 32'hFF) : w;
        check("ld_data", last_ld_data, exp);
        check("ld_dest", 32'(last_ld_dest), 32'(dest));
        if (chk_lat) check("ld_latency", last_ld_cyc - acc_cyc, 2);
      end
    end else begin
      check("st_no_ld", ld_cnt - ld0, 0);
      if (!abrt) begin
        if (by) ref_mem[addr[9:2]] = (w & ~(32'hFF << sh)) | ({24'h0, wdata[7:0]} << sh);
        else    ref_mem[addr[9:2]] = wdata;
      end
    end
  endtask

  task automatic do_fetch(input logic [31:0] addr);
    int f0, k;
    logic [1:0] exp_trans;
    f0 = f_cnt;
    exp_trans = (pf_ok && addr == pf_addr + 32'd4) ? 2'b11 : 2'b10;
    @(negedge clk);
    bus.fetch_req_i  = 1'b1;
    bus.fetch_addr_i = addr;
    k = 0;
    while (f_cnt == f0 && k < 64) begin @(negedge clk); k++; end
    bus.fetch_req_i = 1'b0;
    check("fetch_done", (k < 64) ? 1 : 0, 1);
    check("fetch_trans", 32'(last_trans), 32'(exp_trans));
    check("fetch_instr", last_f, ref_mem[addr[9:2]]);
    pf_ok   = 1'b1;
    pf_addr = addr;
  endtask

  initial begin
    int k, hi, f0, l0, a0, i0, w0, nbad, r;
    logic [31:0] addr;
    bus.req_valid_i  = 1'b0;
    bus.req_write_i  = 1'b0;
    bus.req_byte_i   = 1'b0;
    bus.req_addr_i   = '0;
    bus.req_wdata_i  = '0;
    bus.req_dest_i   = '0;
    bus.fetch_req_i  = 1'b0;
    bus.fetch_addr_i = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[64]     = 32'h44332211;
    ref_mem[64] = 32'h44332211;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready_o), 0);
    check("rst_trans", 32'(bus.mem_trans_o), 0);
    check("rst_ld_valid", 32'(bus.ld_valid_o), 0);
    check("rst_addr", bus.mem_addr_o, 0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(bus.req_ready_o), 1);

    // Word and byte loads
    do_data(1'b0, 1'b0, 32'h100, 32'h0, 4'd3, 1'b0, 1'b1);
    do_data(1'b0, 1'b1, 32'h102, 32'h0, 4'd4, 1'b0, 1'b1);

    // Byte store through read-modify-write
    i0 = issue_cnt;
    w0 = wr_issue;
    do_data(1'b1, 1'b1, 32'h101, 32'h123456AB, 4'd0, 1'b0, 1'b0);
    check("rmw_word", mem[64], 32'h4433AB11);
    check("rmw_issues", issue_cnt - i0, 2);
    check("rmw_writes", wr_issue - w0, 1);
    check("write_outside_issue", wr_bad, 0);

    // Sequential fetch detection
    do_fetch(32'h0);
    do_fetch(32'h4);
    do_data(1'b0, 1'b0, 32'h100, 32'h0, 4'd1, 1'b0, 1'b0);
    do_fetch(32'h8);

    // Load and fetch requested together: load first, then fetch
    f0 = f_cnt;
    l0 = ld_cnt;
    @(negedge clk);
    bus.req_valid_i  = 1'b1;
    bus.req_write_i  = 1'b0;
    bus.req_byte_i   = 1'b0;
    bus.req_addr_i   = 32'h100;
    bus.req_dest_i   = 4'd5;
    bus.fetch_req_i  = 1'b1;
    bus.fetch_addr_i = 32'h10;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    hi = 0;
    k  = 0;
    while (f_cnt == f0 && k < 64) begin
      if (bus.req_ready_o) hi++;
      @(negedge clk);
      k++;
    end
    bus.fetch_req_i = 1'b0;
    check("dual_done", (k < 64) ? 1 : 0, 1);
    check("dual_ld_cnt", ld_cnt - l0, 1);
    check("dual_ld_data", last_ld_data, ref_mem[64]);
    check("dual_ld_dest", 32'(last_ld_dest), 5);
    check("dual_instr", last_f, ref_mem[4]);
    check("dual_trans", 32'(last_trans), 32'(2'b10));
    check("dual_ready_gap", hi, 1);
    check("dual_order", (ev_q.size() >= 2) ? ev_q[ev_q.size()-2] * 10 + ev_q[ev_q.size()-1] : 0, 12);
    pf_ok   = 1'b1;
    pf_addr = 32'h10;

    // Timeout with no data_valid
    stall_mode = 1'b1;
    do_data(1'b0, 1'b0, 32'h200, 32'h0, 4'd9, 1'b1, 1'b0);
    check("timeout_lat", last_ab_cyc - issue_cyc, TMO);
    check("timeout_ready", 32'(bus.req_ready_o), 1);
    stall_mode = 1'b0;

    // Reset while a load is outstanding; the late response must be ignored
    resp_lat = 4;
    l0 = ld_cnt;
    a0 = ab_cnt;
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_write_i = 1'b0;
    bus.req_byte_i  = 1'b0;
    bus.req_addr_i  = 32'h100;
    bus.req_dest_i  = 4'd6;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_trans", 32'(bus.mem_trans_o), 0);
    check("mid_rst_addr", bus.mem_addr_o, 0);
    check("mid_rst_ld_data", bus.ld_data_o, 0);
    check("mid_rst_others", 32'(|{bus.req_ready_o, bus.ld_valid_o, bus.ld_dest_o, bus.fetch_valid_o,
                                  bus.fetch_instr_o, bus.mem_wdata_o, bus.mem_write_o,
                                  bus.mem_size_o, bus.abort_o}), 0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("late_valid_no_ld", ld_cnt - l0, 0);
    check("late_valid_no_abort", ab_cnt - a0, 0);
    check("post_rst_ready", 32'(bus.req_ready_o), 1);
    pf_ok = 1'b0;

    // Randomized mix
    for (int n = 0; n < 60; n++) begin
      resp_lat = $urandom_range(1, 3);
      r = $urandom_range(0, 4);
      addr = 32'($urandom_range(0, 1023));
      if (r == 4) begin
        if (pf_ok && $urandom_range(0, 1) == 1) addr = pf_addr + 32'd4;
        else addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        do_fetch(addr);
      end else begin
        do_data(r >= 2, r[0], addr, $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 7) == 0, 1'b0);
      end
    end

    nbad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nbad++;
    check("mem_final", nbad, 0);
    check("bus_size_align", bus_bad, 0);
    check("write_strobe_final", wr_bad, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
